// File: rtl/roic_scan_timing_gen.sv
// Scan timing generator for the ROIC gate/XAO drivers: a back-bias phase followed by
// one or more flush passes, exposed as row/column counters plus phase indices.
module roic_scan_timing_gen #(
    parameter int CNT_W = 16,
    parameter int REP_W = 4
) (
    input  logic             fsm_clk,
    input  logic             fsm_drv_rst,
    input  logic             scan_start,
    input  logic             scan_abort,
    input  logic [CNT_W-1:0] col_max,
    input  logic [CNT_W-1:0] bb_rows,
    input  logic [CNT_W-1:0] flush_rows,
    input  logic [REP_W-1:0] flush_repeat,
    output logic [CNT_W-1:0] row_cnt,
    output logic [CNT_W-1:0] col_cnt,
    output logic             col_end,
    output logic             fsm_back_bias_index,
    output logic             fsm_flush_index,
    output logic             busy,
    output logic             scan_done,
    output logic [REP_W-1:0] pass_cnt,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BB    = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] col_max_s;
    logic [CNT_W-1:0] bb_rows_s;
    logic [CNT_W-1:0] flush_rows_s;
    logic [REP_W-1:0] flush_repeat_s;

    logic             active;
    logic [CNT_W-1:0] rows_cur;
    logic             last_row;

    // Row limit of whichever phase is running; only meaningful while active.
    assign active   = (state == BB) || (state == FLUSH);
    assign rows_cur = (state == BB) ? bb_rows_s : flush_rows_s;
    assign last_row = (row_cnt == (rows_cur - CNT_ONE));

    assign col_end             = active && (col_cnt == col_max_s);
    assign fsm_back_bias_index = (state == BB);
    assign fsm_flush_index     = (state == FLUSH);
    assign busy                = (state != IDLE);
    assign scan_done           = (state == DONE);
    assign fsm_state           = state;

    always_ff @(posedge fsm_clk or negedge fsm_drv_rst) begin
        if (!fsm_drv_rst) begin
            state          <= IDLE;
            row_cnt        <= '0;
            col_cnt        <= '0;
            pass_cnt       <= '0;
            col_max_s      <= '0;
            bb_rows_s      <= '0;
            flush_rows_s   <= '0;
            flush_repeat_s <= '0;
        end else if (scan_abort) begin
            state    <= IDLE;
            row_cnt  <= '0;
            col_cnt  <= '0;
            pass_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        col_max_s      <= col_max;
                        bb_rows_s      <= bb_rows;
                        flush_rows_s   <= flush_rows;
                        flush_repeat_s <= flush_repeat;
                        row_cnt        <= '0;
                        col_cnt        <= '0;
                        pass_cnt       <= '0;
                        if (bb_rows != '0)         state <= BB;
                        else if (flush_rows != '0) state <= FLUSH;
                        else                       state <= DONE;
                    end
                end
                BB, FLUSH: begin
                    if (col_end) begin
                        col_cnt <= '0;
                        if (last_row) begin
                            row_cnt <= '0;
                            if (state == BB) begin
                                pass_cnt <= '0;
                                state    <= (flush_rows_s != '0) ? FLUSH : DONE;
                            end else if (pass_cnt != flush_repeat_s) begin
                                // Next flush pass starts with no gap in the index.
                                pass_cnt <= pass_cnt + REP_ONE;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            row_cnt <= row_cnt + CNT_ONE;
                        end
                    end else begin
                        col_cnt <= col_cnt + CNT_ONE;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    pass_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_roic_scan_timing_gen.sv
// Bench for roic_scan_timing_gen: a trace-generating model fills an expected queue on
// each accepted start, a negedge monitor compares every cycle, directed checks pin it.
module tb_roic_scan_timing_gen;

    localparam int W = 43;

    logic        fsm_clk;
    logic        fsm_drv_rst;
    logic        scan_start;
    logic        scan_abort;
    logic [15:0] col_max;
    logic [15:0] bb_rows;
    logic [15:0] flush_rows;
    logic [3:0]  flush_repeat;
    logic [15:0] row_cnt;
    logic [15:0] col_cnt;
    logic        col_end;
    logic        fsm_back_bias_index;
    logic        fsm_flush_index;
    logic        busy;
    logic        scan_done;
    logic [3:0]  pass_cnt;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    logic         cur_busy = 1'b0;
    logic [W-1:0] dut_v;

    roic_scan_timing_gen #(.CNT_W(16), .REP_W(4)) dut (
        .fsm_clk             (fsm_clk),
        .fsm_drv_rst         (fsm_drv_rst),
        .scan_start          (scan_start),
        .scan_abort          (scan_abort),
        .col_max             (col_max),
        .bb_rows             (bb_rows),
        .flush_rows          (flush_rows),
        .flush_repeat        (flush_repeat),
        .row_cnt             (row_cnt),
        .col_cnt             (col_cnt),
        .col_end             (col_end),
        .fsm_back_bias_index (fsm_back_bias_index),
        .fsm_flush_index     (fsm_flush_index),
        .busy                (busy),
        .scan_done           (scan_done),
        .pass_cnt            (pass_cnt),
        .fsm_state           (fsm_state)
    );

    assign dut_v = {fsm_state, row_cnt, col_cnt, col_end, fsm_back_bias_index,
                    fsm_flush_index, busy, scan_done, pass_cnt};

    // ---------------- clock / reset ----------------
    initial begin
        fsm_clk = 1'b0;
        forever #20 fsm_clk = ~fsm_clk;
    end

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    // ---------------- model ----------------
    function automatic logic [W-1:0] mk(input logic [1:0] st, input int row, input int col,
                                        input logic ce, input int pass);
        return {st, 16'(row), 16'(col), ce, st == 2'd1, st == 2'd2, st != 2'd0,
                st == 2'd3, 4'(pass)};
    endfunction

    // One entry per cycle following the start edge, straight from the scan rules.
    function automatic void push_scan(input int cm, input int bb, input int fr, input int rep);
        if (bb != 0)
            for (int r = 0; r < bb; r++)
                for (int c = 0; c <= cm; c++)
                    exp_q.push_back(mk(2'd1, r, c, c == cm, 0));
        if (fr != 0)
            for (int p = 0; p <= rep; p++)
                for (int r = 0; r < fr; r++)
                    for (int c = 0; c <= cm; c++)
                        exp_q.push_back(mk(2'd2, r, c, c == cm, p));
        exp_q.push_back(mk(2'd3, 0, 0, 1'b0, (fr != 0) ? rep : 0));
    endfunction

    always @(posedge fsm_clk) begin
        if (!fsm_drv_rst) exp_q.delete();
        else if (scan_abort) begin
            if (cur_busy) exp_q.delete();
        end else if (scan_start && !cur_busy)
            push_scan(int'(col_max), int'(bb_rows), int'(flush_rows), int'(flush_repeat));
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge fsm_clk) begin
        logic [W-1:0] exp_v;
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
        else                  exp_v = mk(2'd0, 0, 0, 1'b0, 0);
        check("cycle", 64'(dut_v), 64'(exp_v));
        cur_busy = exp_v[5];
    end

    // ---------------- drivers ----------------
    task automatic wait_k(input int n);
        repeat (n) @(posedge fsm_clk);
        #1;
    endtask

    // Returns #1 into the first cycle after the start edge; inputs are then scrambled.
    task automatic start_scan(input logic [15:0] cm, input logic [15:0] bb,
                              input logic [15:0] fr, input logic [3:0] rep);
        @(posedge fsm_clk); #1;
        col_max = cm; bb_rows = bb; flush_rows = fr; flush_repeat = rep;
        scan_start = 1'b1;
        @(posedge fsm_clk); #1;
        scan_start = 1'b0;
        col_max = 16'($urandom); bb_rows = 16'($urandom);
        flush_rows = 16'($urandom); flush_repeat = 4'($urandom);
    endtask

    initial begin
        fsm_drv_rst = 1'b0; scan_start = 1'b0; scan_abort = 1'b0;
        col_max = '0; bb_rows = '0; flush_rows = '0; flush_repeat = '0;
        #5;
        check("reset_outputs", 64'(dut_v), 64'(0));
        wait_k(3);
        fsm_drv_rst = 1'b1;
        wait_k(2);

        // basic scan
        start_scan(16'd3, 16'd2, 16'd2, 4'd0);
        check("t1_k1", {fsm_back_bias_index, fsm_flush_index, row_cnt, col_cnt}, {2'b10, 32'd0});
        wait_k(3);
        check("t1_k4", {col_end, row_cnt, col_cnt}, {1'b1, 16'd0, 16'd3});
        wait_k(1);
        check("t1_k5", {col_end, row_cnt, col_cnt}, {1'b0, 16'd1, 16'd0});
        wait_k(4);
        check("t1_k9", {fsm_back_bias_index, fsm_flush_index, row_cnt, pass_cnt}, {2'b01, 16'd0, 4'd0});
        wait_k(7);
        check("t1_k16", {fsm_flush_index, col_end, row_cnt}, {2'b11, 16'd1});
        wait_k(1);
        check("t1_done", {scan_done, busy, fsm_flush_index}, 3'b110);
        wait_k(1);
        check("t1_idle", {scan_done, busy}, 2'b00);

        // repeated flush passes
        start_scan(16'd1, 16'd0, 16'd1, 4'd2);
        check("t2_k1", {fsm_state, fsm_flush_index, pass_cnt}, {2'd2, 1'b1, 4'd0});
        wait_k(2);
        check("t2_k3", {fsm_flush_index, pass_cnt}, {1'b1, 4'd1});
        wait_k(2);
        check("t2_k5", {fsm_flush_index, pass_cnt}, {1'b1, 4'd2});
        wait_k(2);
        check("t2_done", {scan_done, fsm_flush_index}, 2'b10);
        wait_k(2);

        // both phases skipped
        start_scan(16'd5, 16'd0, 16'd0, 4'd3);
        check("t3_done", {fsm_state, scan_done, busy, fsm_back_bias_index, fsm_flush_index},
              {2'd3, 4'b1100});
        wait_k(1);
        check("t3_idle", {fsm_state, busy}, 3'b000);
        wait_k(2);

        // col_max = 0
        start_scan(16'd0, 16'd3, 16'd0, 4'd0);
        for (int r = 0; r < 3; r++) begin
            check("t4_row", {col_end, row_cnt}, {1'b1, 16'(r)});
            wait_k(1);
        end
        check("t4_done", scan_done, 1'b1);
        wait_k(2);

        // col_max = 0xFFFF wrap, then abort
        start_scan(16'hFFFF, 16'd2, 16'd0, 4'd0);
        wait_k(65535);
        check("t5_top", {col_end, row_cnt, col_cnt}, {1'b1, 16'd0, 16'hFFFF});
        wait_k(1);
        check("t5_wrap", {col_end, row_cnt, col_cnt}, {1'b0, 16'd1, 16'd0});
        scan_abort = 1'b1;
        wait_k(1);
        scan_abort = 1'b0;
        wait_k(2);

        // abort during FLUSH row 1 col 2
        start_scan(16'd3, 16'd0, 16'd2, 4'd0);
        wait_k(6);
        check("t6_pos", {fsm_flush_index, row_cnt, col_cnt}, {1'b1, 16'd1, 16'd2});
        scan_abort = 1'b1;
        wait_k(1);
        scan_abort = 1'b0;
        check("t6_abort", {fsm_state, busy, scan_done, row_cnt, col_cnt}, 36'd0);
        wait_k(1);
        check("t6_no_done", scan_done, 1'b0);
        wait_k(2);

        // asynchronous reset mid-BB
        start_scan(16'd3, 16'd2, 16'd1, 4'd0);
        wait_k(5);
        #10;
        fsm_drv_rst = 1'b0;
        exp_q.delete();
        cur_busy = 1'b0;
        #1;
        check("t7_async_rst", 64'(dut_v), 64'(0));
        wait_k(1);
        fsm_drv_rst = 1'b1;
        wait_k(2);

        // start while busy and shadow registers
        start_scan(16'd3, 16'd2, 16'd2, 4'd0);
        bb_rows = 16'd5; col_max = 16'd7;
        wait_k(2);
        scan_start = 1'b1;
        wait_k(1);
        scan_start = 1'b0;
        check("t8_still_bb", {fsm_back_bias_index, row_cnt, col_cnt}, {1'b1, 16'd0, 16'd3});
        wait_k(5);
        check("t8_flush", {fsm_back_bias_index, fsm_flush_index}, 2'b01);
        wait_k(8);
        check("t8_done", scan_done, 1'b1);
        wait_k(2);

        // randomized scans with random aborts and stray starts
        for (int it = 0; it < 40; it++) begin
            start_scan(16'($urandom_range(0, 5)), 16'($urandom_range(0, 3)),
                       16'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            repeat ($urandom_range(5, 100)) begin
                @(posedge fsm_clk); #1;
                scan_start   = ($urandom_range(0, 15) == 0);
                scan_abort   = ($urandom_range(0, 29) == 0);
                col_max      = 16'($urandom_range(0, 5));
                bb_rows      = 16'($urandom_range(0, 3));
                flush_rows   = 16'($urandom_range(0, 3));
                flush_repeat = 4'($urandom_range(0, 3));
            end
            scan_start = 1'b0;
            scan_abort = 1'b0;
            wait_k(120);
            check("rand_idle", busy, 1'b0);
        end

        wait_k(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
